// File: rtl/flash_loader.sv
// Loads a length-prefixed little-endian word image from a byte stream into
// the instruction flash port, holding the core in reset until it is written.
//
// state   | meaning
// HDR0    | waiting for word count low byte
// HDR1    | waiting for word count high byte
// DATA    | collecting the 4 bytes of the next word
// WRITE   | one-cycle flash write strobe
// RELEASE | settle delay, core still in reset
// DONE    | image loaded, core released, stream ignored
module flash_loader #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR   = '0,
  parameter int               HOLD_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] flash_addr,
  output logic [WIDTH-1:0] flash_data,
  output logic             flash_en,
  output logic             core_rst,
  output logic             done,
  output logic [15:0]      loaded_words
);

  typedef enum logic [2:0] {
    HDR0    = 3'd0,
    HDR1    = 3'd1,
    DATA    = 3'd2,
    WRITE   = 3'd3,
    RELEASE = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] word_cnt;
  logic [1:0]  byte_idx;
  logic [23:0] shift;
  logic [15:0] hold_cnt;
  logic        accept;
  logic        last_word;

  assign accept    = in_valid && in_ready;
  assign last_word = (loaded_words + 16'd1) == word_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= HDR0;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    flash_en  = 1'b0;
    core_rst  = 1'b1;
    done      = 1'b0;
    case (state)
      HDR0: begin
        in_ready = !rst;
        if (accept) state_nxt = HDR1;
      end
      HDR1: begin
        in_ready = !rst;
        if (accept) state_nxt = ({in_data, word_cnt[7:0]} == 16'd0) ? RELEASE : DATA;
      end
      DATA: begin
        in_ready = !rst;
        if (accept && byte_idx == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        flash_en  = !rst;
        state_nxt = last_word ? RELEASE : DATA;
      end
      RELEASE: begin
        if (hold_cnt == 16'd0) state_nxt = DONE;
      end
      DONE: begin
        core_rst = rst;
        done     = !rst;
      end
      default: state_nxt = HDR0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt     <= '0;
      byte_idx     <= '0;
      shift        <= '0;
      hold_cnt     <= HOLD_LOAD;
      flash_addr   <= '0;
      flash_data   <= '0;
      loaded_words <= '0;
    end else begin
      case (state)
        HDR0: begin
          if (accept) word_cnt[7:0] <= in_data;
        end
        HDR1: begin
          if (accept) begin
            word_cnt[15:8] <= in_data;
            byte_idx       <= '0;
            hold_cnt       <= HOLD_LOAD;
          end
        end
        DATA: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: shift[7:0]   <= in_data;
              2'd1: shift[15:8]  <= in_data;
              2'd2: shift[23:16] <= in_data;
              default: begin
                flash_data <= WIDTH'({in_data, shift});
                flash_addr <= BASE_ADDR + WIDTH'({loaded_words, 2'b00});
              end
            endcase
          end
        end
        WRITE: begin
          loaded_words <= loaded_words + 16'd1;
          byte_idx     <= '0;
          hold_cnt     <= HOLD_LOAD;
        end
        RELEASE: begin
          if (hold_cnt != 16'd0) hold_cnt <= hold_cnt - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_loader.sv
// Randomized bench for flash_loader: a byte-count based reference model checks
// two instances (base 0 and base 0x100) every cycle, plus literal scenario checks.
module tb_flash_loader;
  localparam int H = 3;
  localparam logic [31:0] BASE_B = 32'h100;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {int c; logic [31:0] a; logic [31:0] d;} wr_t;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic        rdy_a, en_a, crst_a, done_a, rdy_b, en_b, crst_b, done_b;
  logic [31:0] addr_a, data_a, addr_b, data_b;
  logic [15:0] lw_a, lw_b;

  flash_loader #(.WIDTH(32), .BASE_ADDR(32'h0), .HOLD_CYCLES(H)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
    .flash_addr(addr_a), .flash_data(data_a), .flash_en(en_a), .core_rst(crst_a),
    .done(done_a), .loaded_words(lw_a));

  flash_loader #(.WIDTH(32), .BASE_ADDR(BASE_B), .HOLD_CYCLES(H)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_b),
    .flash_addr(addr_b), .flash_data(data_b), .flash_en(en_b), .core_rst(crst_b),
    .done(done_b), .loaded_words(lw_b));

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, nprint = 0;
  int done_cyc = -1, acc_cyc = -1;
  wr_t log_a[$], log_b[$];

  // reference model: progress is tracked as a count of bytes in the frame
  int          m_cnt = 0, m_words = 0, m_rel = 0, m_last_idx = 0;
  logic [15:0] m_n = 0;
  logic [7:0]  m_buf[3];
  logic [31:0] m_last_data = 0;
  bit          m_wr = 0, m_done = 0, m_any = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (nprint < 40) begin
        $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        nprint++;
      end
    end
  endtask

  function automatic bit exp_ready();
    return !rst && !m_wr && m_rel == 0 && !m_done;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] base);
    return m_any ? base + 32'(m_last_idx) * 32'd4 : 32'h0;
  endfunction

  always @(posedge clk) begin
    bit acc;
    int k;
    acc = in_valid && exp_ready();
    if (rst) begin
      m_cnt = 0; m_n = 0; m_wr = 0; m_words = 0; m_rel = 0; m_done = 0;
      m_any = 0; m_last_data = 0; m_last_idx = 0;
    end else begin
      if (m_wr) begin
        m_wr = 0;
        m_words++;
        if (m_words == int'(m_n)) m_rel = H;
      end else if (m_rel > 0) begin
        m_rel--;
        if (m_rel == 0) m_done = 1;
      end
      if (acc) begin
        acc_cyc = cyc;
        if (m_cnt == 0) m_n[7:0] = in_data;
        else if (m_cnt == 1) begin
          m_n[15:8] = in_data;
          if (m_n == 16'd0) m_rel = H;
        end else begin
          k = (m_cnt - 2) % 4;
          if (k < 3) m_buf[k] = in_data;
          else begin
            m_wr = 1;
            m_any = 1;
            m_last_idx = m_words;
            m_last_data = {in_data, m_buf[2], m_buf[1], m_buf[0]};
          end
        end
        m_cnt++;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    chk("in_ready_a", 32'(rdy_a), 32'(exp_ready()));
    chk("in_ready_b", 32'(rdy_b), 32'(exp_ready()));
    chk("flash_en_a", 32'(en_a), 32'(m_wr && !rst));
    chk("flash_en_b", 32'(en_b), 32'(m_wr && !rst));
    chk("core_rst_a", 32'(crst_a), 32'(rst || !m_done));
    chk("core_rst_b", 32'(crst_b), 32'(rst || !m_done));
    chk("done_a", 32'(done_a), 32'(!rst && m_done));
    chk("done_b", 32'(done_b), 32'(!rst && m_done));
    if (!rst) begin
      chk("loaded_words_a", 32'(lw_a), 32'(m_words));
      chk("loaded_words_b", 32'(lw_b), 32'(m_words));
      chk("flash_addr_a", addr_a, exp_addr(32'h0));
      chk("flash_addr_b", addr_b, exp_addr(BASE_B));
      chk("flash_data_a", data_a, m_last_data);
      chk("flash_data_b", data_b, m_last_data);
    end
    if (en_a === 1'b1) log_a.push_back('{cyc, addr_a, data_a});
    if (en_b === 1'b1) log_b.push_back('{cyc, addr_b, data_b});
    if (done_a === 1'b1 && done_cyc < 0) done_cyc = cyc;
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int g;
    bit ok;
    ok = 0;
    g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    repeat (g) begin in_valid = 1'b0; in_data = 8'($urandom); tick(); end
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); ok = rdy_a;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_byte timeout: byte %h never accepted, want accept within 200 cycles", b);
    end
  endtask

  task automatic send_frame(input byte_q_t q, input int gapmax);
    foreach (q[i]) send_byte(q[i], gapmax);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); ok = (done_a === 1'b1);
    end
    tick();
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_done timeout: done=0 after 100 cycles, want 1");
    end
  endtask

  task automatic do_reset(input bit keep_valid);
    rst = 1'b1; in_valid = keep_valid; in_data = 8'($urandom);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    log_a.delete(); log_b.delete(); done_cyc = -1;
  endtask

  task automatic check_log(input string tag, input logic [31:0] exp_d[$], input bit spacing);
    chk({tag, "_count"}, 32'(log_a.size()), 32'(exp_d.size()));
    chk({tag, "_count_b"}, 32'(log_b.size()), 32'(exp_d.size()));
    if (log_a.size() == exp_d.size() && log_b.size() == exp_d.size()) begin
      foreach (exp_d[i]) begin
        chk({tag, "_addr"}, log_a[i].a, 32'(i * 4));
        chk({tag, "_addr_b"}, log_b[i].a, BASE_B + 32'(i * 4));
        chk({tag, "_data"}, log_a[i].d, exp_d[i]);
        if (spacing && i > 0) chk({tag, "_spacing"}, 32'(log_a[i].c - log_a[i-1].c), 32'd5);
      end
      if (exp_d.size() > 0)
        chk({tag, "_release_delay"}, 32'(done_cyc - log_a[exp_d.size()-1].c), 32'd4);
    end
  endtask

  initial begin
    byte_q_t nom, q;
    logic [31:0] nom_d[$], d[$];
    int n, cut, nwr;
    nom = '{8'h05, 8'h00, 8'h83, 8'h27, 8'h80, 8'h02, 8'h33, 8'h46, 8'hc6, 8'h00,
            8'h13, 8'h06, 8'h16, 8'h00, 8'he3, 8'h0c, 8'hf6, 8'hfe, 8'h6f, 8'h00, 8'h00, 8'h00};
    nom_d = '{32'h02802783, 32'h00c64633, 32'h00160613, 32'hfef60ce3, 32'h0000006f};

    #2; tick(); tick();
    @(negedge clk);
    chk("rst_in_ready", 32'(rdy_a), 32'd0);
    chk("rst_core_rst", 32'(crst_a), 32'd1);
    chk("rst_flash_en", 32'(en_a), 32'd0);
    chk("rst_loaded", 32'(lw_a), 32'd0);
    tick();
    rst = 1'b0; log_a.delete(); log_b.delete();
    @(negedge clk);
    chk("idle_in_ready", 32'(rdy_a), 32'd1);
    chk("idle_addr", addr_a, 32'h0);
    chk("idle_data", data_a, 32'h0);
    chk("idle_done", 32'(done_a), 32'd0);
    tick();

    send_frame(nom, 0);
    wait_done();
    check_log("nominal", nom_d, 1);
    chk("nominal_loaded", 32'(lw_a), 32'd5);
    chk("nominal_done", 32'(done_a), 32'd1);

    do_reset(0);
    send_frame('{8'h00, 8'h00}, 0);
    n = acc_cyc;
    wait_done();
    chk("zero_count", 32'(log_a.size()), 32'd0);
    chk("zero_release_delay", 32'(done_cyc - n), 32'd4);

    do_reset(0);
    send_frame(nom, 7);
    wait_done();
    check_log("gaps", nom_d, 0);

    do_reset(0);
    q = nom[0:7];
    send_frame(q, 2);
    do_reset(1);
    send_frame('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 1);
    wait_done();
    check_log("midreset", '{32'h12345678}, 0);
    chk("midreset_loaded", 32'(lw_a), 32'd1);

    do_reset(0);
    send_frame('{8'h02, 8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22}, 1);
    wait_done();
    check_log("base", '{32'h11111111, 32'h22222222}, 0);
    if (log_b.size() == 2) begin
      chk("base_addr0", log_b[0].a, 32'h100);
      chk("base_addr1", log_b[1].a, 32'h104);
    end
    nwr = log_a.size();
    in_valid = 1'b1;
    repeat (10) begin in_data = 8'($urandom); tick(); end
    in_valid = 1'b0;
    chk("postdone_writes", 32'(log_a.size()), 32'(nwr));
    chk("postdone_done", 32'(done_a), 32'd1);
    chk("postdone_ready", 32'(rdy_a), 32'd0);

    for (int it = 0; it < 8; it++) begin
      do_reset(0);
      n = int'($urandom_range(4, 0));
      q = '{8'(n), 8'h00};
      d.delete();
      for (int w = 0; w < n; w++) begin
        logic [31:0] word;
        word = $urandom;
        d.push_back(word);
        for (int b = 0; b < 4; b++) q.push_back(word[8*b +: 8]);
      end
      if ($urandom_range(2, 0) == 0 && q.size() > 2) begin
        cut = int'($urandom_range(q.size() - 1, 1));
        send_frame(q[0:cut-1], 3);
      end else begin
        send_frame(q, 3);
        wait_done();
        check_log("random", d, 0);
        chk("random_loaded", 32'(lw_a), 32'(n));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 2ms");
    $fatal(1);
  end
endmodule
